// File: rtl/btn_gesture_pkg.sv
// Shared types and helpers for the multi-channel button gesture decoder.
package btn_gesture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2,
    ST_LONG  = 2'd3
  } gest_state_e;

  // Timer only ever holds values up to the largest *_CYC minus one.
  function automatic int unsigned timer_width(input int unsigned long_cyc,
                                              input int unsigned gap_cyc,
                                              input int unsigned rep_cyc);
    int unsigned max_cyc;
    max_cyc = long_cyc;
    if (gap_cyc > max_cyc) max_cyc = gap_cyc;
    if (rep_cyc > max_cyc) max_cyc = rep_cyc;
    return (max_cyc < 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage

// File: rtl/btn_gesture_decoder_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button channel.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

  if (DEB_CYC < 2) begin : g_param_err
    $error("btn_debounce: DEB_CYC must be at least 2");
  end

  logic [1:0]    sync_q;
  logic [DW-1:0] stab_cnt;
  logic          settle_c;

  // Strobes fire in the cycle before the debounced level flips.
  assign settle_c = (sync_q[1] != level) && (stab_cnt == DW'(DEB_CYC - 1));
  assign rise_c   = settle_c & ~level;
  assign fall_c   = settle_c & level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      stab_cnt <= '0;
      level    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      if (sync_q[1] == level) begin
        stab_cnt <= '0;
      end else if (settle_c) begin
        level    <= ~level;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/btn_gesture_decoder.sv
// Per-channel button gesture decoder: multi-click count, long press, held level
// and auto-repeat, each channel debounced and classified independently.
module btn_gesture_decoder
  import btn_gesture_pkg::*;
#(
  parameter int unsigned N_BTN      = 1,
  parameter int unsigned DEB_CYC    = 1000000,
  parameter int unsigned LONG_CYC   = 100000000,
  parameter int unsigned GAP_CYC    = 30000000,
  parameter int unsigned REP_CYC    = 10000000,
  parameter int unsigned MAX_CLICKS = 4,
  localparam int unsigned CW        = $clog2(MAX_CLICKS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_BTN-1:0]    btn,
  output logic [N_BTN-1:0]    click_pulse,
  output logic [N_BTN*CW-1:0] click_count,
  output logic [N_BTN-1:0]    long_pulse,
  output logic [N_BTN-1:0]    held,
  output logic [N_BTN-1:0]    repeat_pulse
);

  localparam int unsigned TW = timer_width(LONG_CYC, GAP_CYC, REP_CYC);

  if (DEB_CYC < 2 || LONG_CYC < 2 || GAP_CYC < 2 || REP_CYC < 2 ||
      MAX_CLICKS < 1) begin : g_param_err
    $error("btn_gesture_decoder: *_CYC must be >= 2 and MAX_CLICKS >= 1");
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    logic          deb_level;
    logic          deb_rise_c;
    logic          deb_fall_c;
    gest_state_e   state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [CW-1:0] count_q;
    logic          click_q;
    logic          long_q;
    logic          held_q;
    logic          rep_q;

    btn_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn[i]),
      .level  (deb_level),
      .rise_c (deb_rise_c),
      .fall_c (deb_fall_c)
    );

    // Gesture classifier; the timer restarts on every state entry.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        timer   <= '0;
        count_q <= '0;
        click_q <= 1'b0;
        long_q  <= 1'b0;
        held_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        click_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (deb_rise_c) begin
              state <= ST_PRESS;
              cnt   <= CW'(1);
              timer <= '0;
            end
          end
          ST_PRESS: begin
            if (deb_fall_c) begin
              timer <= '0;
              if (cnt == CW'(MAX_CLICKS)) begin
                click_q <= 1'b1;
                count_q <= cnt;
                cnt     <= '0;
                state   <= ST_IDLE;
              end else begin
                state <= ST_GAP;
              end
            end else if (cnt == CW'(1)) begin
              // Only a first press can turn into a long hold.
              if (timer == TW'(LONG_CYC - 1)) begin
                long_q <= 1'b1;
                held_q <= 1'b1;
                timer  <= '0;
                state  <= ST_LONG;
              end else begin
                timer <= timer + TW'(1);
              end
            end
          end
          ST_GAP: begin
            // A new press beats a simultaneous gap timeout.
            if (deb_rise_c) begin
              cnt   <= cnt + CW'(1);
              timer <= '0;
              state <= ST_PRESS;
            end else if (timer == TW'(GAP_CYC - 1)) begin
              click_q <= 1'b1;
              count_q <= cnt;
              cnt     <= '0;
              timer   <= '0;
              state   <= ST_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_LONG: begin
            if (deb_fall_c) begin
              held_q <= 1'b0;
              cnt    <= '0;
              timer  <= '0;
              state  <= ST_IDLE;
            end else if (timer == TW'(REP_CYC - 1)) begin
              rep_q <= 1'b1;
              timer <= '0;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end

    assign click_pulse[i]         = click_q;
    assign click_count[i*CW +: CW] = count_q;
    assign long_pulse[i]          = long_q;
    assign held[i]                = held_q;
    assign repeat_pulse[i]        = rep_q;
  end

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// Directed and randomized bench for btn_gesture_decoder with a timestamp-based reference model.
module tb_btn_gesture_decoder;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 40;
  localparam int GAP  = 20;
  localparam int REP  = 10;
  localparam int MAXC = 4;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int M_IDLE = 0;
  localparam int M_DOWN = 1;
  localparam int M_UP   = 2;
  localparam int M_LONG = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    btn;
  logic [N-1:0]    click_pulse;
  logic [N*CW-1:0] click_count;
  logic [N-1:0]    long_pulse;
  logic [N-1:0]    held;
  logic [N-1:0]    repeat_pulse;

  btn_gesture_decoder #(
    .N_BTN      (N),
    .DEB_CYC    (DEB),
    .LONG_CYC   (LONG),
    .GAP_CYC    (GAP),
    .REP_CYC    (REP),
    .MAX_CLICKS (MAXC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .click_pulse  (click_pulse),
    .click_count  (click_count),
    .long_pulse   (long_pulse),
    .held         (held),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Reference model: raw-sample history and event timestamps per channel.
  logic m_s1   [N];
  logic m_hist [N][DEB];
  logic m_deb  [N];
  int   m_mode [N];
  int   m_clicks [N];
  int   m_press_t [N];
  int   m_rel_t [N];
  int   m_long_t [N];
  logic [N-1:0]    e_click, e_long, e_rep, e_held;
  logic [N*CW-1:0] e_count;

  // Observed DUT activity.
  int n_click [N];
  int n_long [N];
  int n_rep [N];
  int n_strobe = 0;
  int last_click_t [N];
  int last_long_t [N];
  int last_cnt [N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_s1[c] = 1'b0;
      m_deb[c] = 1'b0;
      for (int k = 0; k < DEB; k++) m_hist[c][k] = 1'b0;
      m_mode[c] = M_IDLE;
      m_clicks[c] = 0;
      m_press_t[c] = 0;
      m_rel_t[c] = 0;
      m_long_t[c] = 0;
    end
    e_click = '0; e_long = '0; e_rep = '0; e_held = '0; e_count = '0;
  endtask

  task automatic model_edge();
    logic all_diff, rise, fall;
    e_click = '0; e_long = '0; e_rep = '0;
    for (int c = 0; c < N; c++) begin
      // Level flips once the synchronised input has disagreed for DEB edges running.
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_hist[c][k] == m_deb[c]) all_diff = 1'b0;
      for (int k = DEB - 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
      m_hist[c][0] = m_s1[c];
      m_s1[c] = btn[c];
      rise = all_diff & ~m_deb[c];
      fall = all_diff & m_deb[c];
      if (all_diff) m_deb[c] = ~m_deb[c];

      if (rise) begin
        if (m_mode[c] == M_IDLE) begin
          m_clicks[c] = 1; m_mode[c] = M_DOWN; m_press_t[c] = t;
        end else if (m_mode[c] == M_UP) begin
          m_clicks[c]++; m_mode[c] = M_DOWN; m_press_t[c] = t;
        end
      end else if (fall) begin
        if (m_mode[c] == M_LONG) begin
          e_held[c] = 1'b0; m_mode[c] = M_IDLE;
        end else if (m_mode[c] == M_DOWN) begin
          if (m_clicks[c] == MAXC) begin
            e_click[c] = 1'b1; e_count[c*CW +: CW] = CW'(m_clicks[c]); m_mode[c] = M_IDLE;
          end else begin
            m_mode[c] = M_UP; m_rel_t[c] = t;
          end
        end
      end else if (m_mode[c] == M_DOWN && m_clicks[c] == 1 && t - m_press_t[c] == LONG) begin
        e_long[c] = 1'b1; e_held[c] = 1'b1; m_mode[c] = M_LONG; m_long_t[c] = t;
      end else if (m_mode[c] == M_LONG && (t - m_long_t[c]) % REP == 0) begin
        e_rep[c] = 1'b1;
      end else if (m_mode[c] == M_UP && t - m_rel_t[c] == GAP) begin
        e_click[c] = 1'b1; e_count[c*CW +: CW] = CW'(m_clicks[c]); m_mode[c] = M_IDLE;
      end
    end
  endtask

  task automatic check_outputs();
    total++;
    assert (click_pulse === e_click) else begin
      bad++; $error("FAIL click_pulse t=%0d got=%b exp=%b", t, click_pulse, e_click);
    end
    total++;
    assert (click_count === e_count) else begin
      bad++; $error("FAIL click_count t=%0d got=%h exp=%h", t, click_count, e_count);
    end
    total++;
    assert (long_pulse === e_long) else begin
      bad++; $error("FAIL long_pulse t=%0d got=%b exp=%b", t, long_pulse, e_long);
    end
    total++;
    assert (held === e_held) else begin
      bad++; $error("FAIL held t=%0d got=%b exp=%b", t, held, e_held);
    end
    total++;
    assert (repeat_pulse === e_rep) else begin
      bad++; $error("FAIL repeat_pulse t=%0d got=%b exp=%b", t, repeat_pulse, e_rep);
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic observe();
    if ((click_pulse | long_pulse | repeat_pulse) != '0) n_strobe++;
    for (int c = 0; c < N; c++) begin
      if (click_pulse[c] === 1'b1) begin
        n_click[c]++; last_click_t[c] = t; last_cnt[c] = int'(click_count[c*CW +: CW]);
      end
      if (long_pulse[c] === 1'b1) begin
        n_long[c]++; last_long_t[c] = t;
      end
      if (repeat_pulse[c] === 1'b1) n_rep[c]++;
    end
  endtask

  task automatic step(input logic [N-1:0] b);
    btn = b;
    @(posedge clk);
    t++;
    if (reset) model_reset();
    else model_edge();
    #1;
    check_outputs();
    observe();
  endtask

  task automatic hold(input logic [N-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  int t_raw, c0, c1, l1, r1, s0, used, w;
  logic lvl;
  logic [N-1:0] rnd_lvl;
  int run_left [N];

  initial begin
    for (int c = 0; c < N; c++) begin
      n_click[c] = 0; n_long[c] = 0; n_rep[c] = 0;
      last_click_t[c] = -1; last_long_t[c] = -1; last_cnt[c] = -1;
    end
    reset = 1'b1;
    btn = '0;
    model_reset();
    #1;
    check_outputs();
    hold(2'b00, 3);
    #1 reset = 1'b0;
    hold(2'b00, 5);

    // Single click: count 1, 2+DEB+GAP after the raw release.
    c0 = n_click[0];
    hold(2'b01, 15);
    t_raw = t;
    hold(2'b00, 30);
    chk("single_n", n_click[0] - c0, 1);
    chk("single_cnt", last_cnt[0], 1);
    chk("single_time", last_click_t[0], t_raw + 2 + DEB + GAP);
    chk("single_nolong", n_long[0], 0);

    // Bounce: runs shorter than DEB never settle.
    s0 = n_strobe;
    lvl = 1'b1;
    used = 0;
    while (used < 30) begin
      w = int'($urandom_range(1, 3));
      if (used + w > 30) w = 30 - used;
      hold({1'b0, lvl}, w);
      used += w;
      lvl = ~lvl;
    end
    hold(2'b00, 30);
    chk("bounce_strobes", n_strobe - s0, 0);

    // Triple click.
    c0 = n_click[0];
    for (int k = 0; k < 3; k++) begin
      hold(2'b01, 10);
      if (k < 2) hold(2'b00, 8);
    end
    t_raw = t;
    hold(2'b00, 30);
    chk("triple_n", n_click[0] - c0, 1);
    chk("triple_cnt", last_cnt[0], 3);
    chk("triple_time", last_click_t[0], t_raw + 2 + DEB + GAP);

    // Max clicks closes on the 4th release; a 5th press starts afresh.
    c0 = n_click[0];
    for (int k = 0; k < MAXC; k++) begin
      hold(2'b01, 10);
      if (k < MAXC - 1) hold(2'b00, 8);
    end
    t_raw = t;
    hold(2'b00, 8);
    chk("max_n", n_click[0] - c0, 1);
    chk("max_cnt", last_cnt[0], MAXC);
    chk("max_time", last_click_t[0], t_raw + 2 + DEB);
    hold(2'b01, 10);
    t_raw = t;
    hold(2'b00, 30);
    chk("fifth_n", n_click[0] - c0, 2);
    chk("fifth_cnt", last_cnt[0], 1);
    chk("fifth_time", last_click_t[0], t_raw + 2 + DEB + GAP);

    // Long hold on channel 1 with a concurrent single click on channel 0.
    c0 = n_click[0]; c1 = n_click[1]; l1 = n_long[1]; r1 = n_rep[1];
    t_raw = t;
    for (int i = 0; i < 100; i++) step({1'b1, (i >= 10 && i < 22)});
    chk("long_n", n_long[1] - l1, 1);
    chk("long_time", last_long_t[1], t_raw + 2 + DEB + LONG);
    chk("held_on", int'(held[1]), 1);
    hold(2'b00, 40);
    chk("rep_n", n_rep[1] - r1, (100 - LONG - 1) / REP);
    chk("held_off", int'(held[1]), 0);
    chk("long_noclick", n_click[1] - c1, 0);
    chk("conc_n", n_click[0] - c0, 1);
    chk("conc_cnt", last_cnt[0], 1);

    // Asynchronous reset in the gap after two clicks.
    c0 = n_click[0];
    hold(2'b01, 10);
    hold(2'b00, 8);
    hold(2'b01, 10);
    hold(2'b00, 12);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_count", int'(click_count), 0);
    hold(2'b00, 2);
    #1 reset = 1'b0;
    hold(2'b00, 40);
    chk("rst_noclick", n_click[0] - c0, 0);
    hold(2'b01, 10);
    t_raw = t;
    hold(2'b00, 30);
    chk("rst_fresh_n", n_click[0] - c0, 1);
    chk("rst_fresh_cnt", last_cnt[0], 1);

    // Random soak against the model.
    for (int c = 0; c < N; c++) run_left[c] = 0;
    rnd_lvl = '0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (run_left[c] == 0) begin
          rnd_lvl[c] = 1'($urandom_range(0, 1));
          run_left[c] = int'($urandom_range(1, 60));
        end
        run_left[c]--;
      end
      step(rnd_lvl);
    end
    hold(2'b00, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_gesture_decoder.md
Name: btn_gesture_decoder

Overview:
- Parametrised successor to the single-button press classifier feeding the clock/alarm FSM.
- Handles N_BTN independent raw buttons. Per channel it synchronises, debounces, and classifies presses into:
  - multi-click events with a click count of 1..MAX_CLICKS,
  - long-press events,
  - a held level,
  - auto-repeat pulses while held.
- Sits between board buttons and the set/alarm FSMs. Replaces hard-wired short/double/triple/four flags with a count bus.

Parameters:
- N_BTN, 1, number of independent button channels
- DEB_CYC, 1000000, consecutive stable cycles required to accept a new debounced level (10 ms @ 100 MHz)
- LONG_CYC, 100000000, hold cycles on a first press before long is declared
- GAP_CYC, 30000000, released cycles that close a click sequence
- REP_CYC, 10000000, auto-repeat period while in long hold
- MAX_CLICKS, 4, click count that closes a sequence immediately
- CW, $clog2(MAX_CLICKS+1), derived width of one count field (localparam)

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- btn, input, N_BTN, raw asynchronous button levels (1 = pressed)
- click_pulse, output, N_BTN, 1-cycle strobe when a click sequence closes
- click_count, output, N_BTN*CW, per-channel click count (channel i at [i*CW +: CW]); updated on click_pulse, held otherwise
- long_pulse, output, N_BTN, 1-cycle strobe when long hold is declared
- held, output, N_BTN, level, 1 while in long hold
- repeat_pulse, output, N_BTN, 1-cycle strobe every REP_CYC cycles during long hold

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). All registers clear on reset:
  - all outputs 0, click_count all 0, debounced level 0, FSM IDLE, timers 0.
- Synchroniser: 2-FF per channel.
- Debounce:
  - Counter increments while the synchronised input differs from the debounced level, and clears when it matches.
  - Debounced level toggles when the counter reaches DEB_CYC-1.
  - Latency from a raw edge (stable from then on) to the debounced edge is 2+DEB_CYC cycles.
- FSM, one per channel, states IDLE, PRESS, GAP, LONG. Timer counts at most max(LONG_CYC, GAP_CYC, REP_CYC) and is cleared on every state entry.
  - IDLE: debounced rise -> PRESS, cnt=1.
  - PRESS, debounced fall:
    - If cnt==MAX_CLICKS: next cycle click_pulse=1, click_count=MAX_CLICKS, -> IDLE.
    - Otherwise -> GAP.
  - PRESS with cnt==1 and timer==LONG_CYC-1 while still pressed: next cycle long_pulse=1, held=1, -> LONG.
  - PRESS with cnt>1: no long timeout; stays in PRESS until release.
  - GAP: debounced rise -> PRESS, cnt+1.
  - GAP with timer==GAP_CYC-1: next cycle click_pulse=1, click_count=cnt, -> IDLE.
  - LONG:
    - repeat_pulse=1 every REP_CYC cycles; the first one comes REP_CYC cycles after long_pulse.
    - Debounced fall -> IDLE, held=0 on that cycle's next edge. No click is reported for a long press.
- Rise and GAP timeout in the same cycle: rise wins (the sequence continues).
- cnt never exceeds MAX_CLICKS. A further press after MAX_CLICKS cannot occur because the sequence closes on release.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset mid-sequence discards the sequence; no event is emitted.
- Elaboration error if any *_CYC < 2 or MAX_CLICKS < 1.

Decomposition:
- Package btn_gesture_pkg holds:
  - the state enum (IDLE, PRESS, GAP, LONG),
  - a width helper for the timer width.
- Sub-module btn_debounce (synchroniser + debounce counter, params DEB_CYC) is instantiated once per channel in a generate loop. The FSM stays in the parent.

Test Plan:
Bench parameters: DEB_CYC=4, LONG_CYC=40, GAP_CYC=20, REP_CYC=10, MAX_CLICKS=4, N_BTN=2.
- Single click: btn0 high 15 cycles, then low.
  -> one click_pulse[0], count=1, exactly 2+4+20 cycles after the raw fall. No long_pulse.
- Bounce: btn0 toggles with 1-3 cycle widths for 30 cycles, ending low.
  -> no debounced edge, no output strobes.
- Triple click: three 10-cycle presses separated by 8-cycle gaps.
  -> exactly one click_pulse, count=3, 20 cycles after the last debounced fall.
- Max clicks: four presses with 8-cycle gaps.
  -> click_pulse with count=4 one cycle after the 4th debounced fall; no gap wait; a fifth press starts a new sequence with count=1.
- Long and repeat: btn1 held 100 cycles.
  -> long_pulse 40 cycles after the debounced rise; held=1; repeat_pulse at +10, +20, …; on release held drops and no click_pulse occurs. Channel 0 clicked concurrently reports count=1 unaffected.
- Reset mid-GAP after 2 clicks.
  -> all outputs 0 immediately (asynchronous). No click_pulse afterwards until a fresh press.
